// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: PC register controls, memory request/response,
// decode handshake and execute redirect. master = fetch unit side.
interface instr_fetch_unit_if #(parameter int AW = 32, parameter int DW = 32);
  logic [AW-1:0] PCCur;
  logic [AW-1:0] PCIn;
  logic          PCSet;
  logic          PCReset;
  logic          ReqValid;
  logic          ReqReady;
  logic [AW-1:0] ReqAddr;
  logic          RespValid;
  logic [DW-1:0] RespData;
  logic          InstrValid;
  logic          InstrReady;
  logic [DW-1:0] InstrData;
  logic [AW-1:0] InstrPC;
  logic          RedirectValid;
  logic [AW-1:0] RedirectTarget;

  modport master (
    input  PCCur, ReqReady, RespValid, RespData, InstrReady, RedirectValid, RedirectTarget,
    output PCIn, PCSet, PCReset, ReqValid, ReqAddr, InstrValid, InstrData, InstrPC
  );
  modport slave (
    output PCCur, ReqReady, RespValid, RespData, InstrReady, RedirectValid, RedirectTarget,
    input  PCIn, PCSet, PCReset, ReqValid, ReqAddr, InstrValid, InstrData, InstrPC
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch front end with a DEPTH-slot ring buffer.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic clk,
  input  logic Reset,
  instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } slot_t;

  slot_t slots [DEPTH];

  logic [PW-1:0] tail, fill, head, drop_cnt;
  logic [PW-1:0] alloc, filled, outst, drop_sum, drop_redir;
  logic          issue, resp_keep, resp_drop, deliver, redir;

  always_comb begin
    alloc  = tail - head;
    filled = fill - head;
    outst  = tail - fill;
    redir  = bus.RedirectValid && !Reset;

    bus.ReqValid   = !Reset && !bus.RedirectValid && (drop_cnt == '0) && (alloc != PW'(DEPTH));
    bus.ReqAddr    = bus.PCCur;
    issue          = bus.ReqValid && bus.ReqReady;

    bus.InstrValid = (filled != '0) && !bus.RedirectValid && !Reset;
    bus.InstrData  = slots[head[IW-1:0]].data;
    bus.InstrPC    = slots[head[IW-1:0]].addr;
    deliver        = bus.InstrValid && bus.InstrReady;

    // A response with nothing outstanding and nothing to drop is simply ignored.
    resp_keep = bus.RespValid && !Reset && !bus.RedirectValid && (drop_cnt == '0) && (outst != '0);
    resp_drop = bus.RespValid && (drop_cnt != '0);

    // Everything still in flight belongs to the old stream; a same-cycle response is one of them.
    drop_sum   = drop_cnt + outst;
    drop_redir = drop_sum - PW'(bus.RespValid && (drop_sum != '0));

    bus.PCReset = Reset;
    bus.PCSet   = 1'b0;
    bus.PCIn    = bus.PCCur;
    if (Reset) begin
      bus.PCIn = '0;
    end else if (bus.RedirectValid) begin
      bus.PCSet = 1'b1;
      bus.PCIn  = bus.RedirectTarget;
    end else if (!issue) begin
      bus.PCSet = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      tail     <= '0;
      fill     <= '0;
      head     <= '0;
      drop_cnt <= '0;
    end else if (redir) begin
      head     <= tail;
      fill     <= tail;
      drop_cnt <= drop_redir;
    end else begin
      if (issue)     tail     <= tail + PW'(1);
      if (resp_keep) fill     <= fill + PW'(1);
      if (resp_drop) drop_cnt <= drop_cnt - PW'(1);
      if (deliver)   head     <= head + PW'(1);
    end
  end

  // Slot storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (issue)     slots[tail[IW-1:0]].addr <= bus.PCCur;
    if (resp_keep) slots[fill[IW-1:0]].data <= bus.RespData;
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (Reset) begin
      FetchCount <= '0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (deliver)       FetchCount <= FetchCount + 32'd1;
      if (!bus.ReqValid) StallCount <= StallCount + 32'd1;
      if (redir)         FlushCount <= FlushCount + 32'd1;
    end
  end
`endif
endmodule
